// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-bit RISC fetch stage.
package fetch_unit_pkg;

  localparam int          AW       = 8;
  localparam int          IW       = 16;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [7:0]  INC      = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Instructions are halfword aligned, so the low target bit carries no information.
  function automatic logic [AW-1:0] align_target(input logic [AW-1:0] addr);
    return {addr[AW-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_gen.sv
// Sequential-PC adder: pc + INC, wrapping modulo 2^AW.
module pc_next_gen
  import fetch_unit_pkg::*;
(
  input  logic [AW-1:0] pc_i,
  output logic [AW-1:0] pc_next_o
);

  assign pc_next_o = pc_i + INC;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, hands off over valid/ready.
// Optional stall-cycle counter enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_rdata_i,
  input  logic          br_valid_i,
  input  logic [AW-1:0] br_target_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [IW-1:0] id_instr_o,
  output logic [AW-1:0] id_pc_o,
`ifdef FETCH_PERF_EN
  output logic [AW-1:0] id_pc_next_o,
  output logic [15:0]   stall_cnt_o
`else
  output logic [AW-1:0] id_pc_next_o
`endif
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic          squash_q, squash_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic [AW-1:0] id_pc_next_q, id_pc_next_d;
  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] br_tgt_s;

  pc_next_gen u_pc_next_gen (
    .pc_i      (pc_q),
    .pc_next_o (pc_inc_s)
  );

  assign br_tgt_s = align_target(br_target_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      squash_q     <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= {IW{1'b0}};
      id_pc_q      <= {AW{1'b0}};
      id_pc_next_q <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      squash_q     <= squash_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_pc_next_q <= id_pc_next_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    squash_d     = squash_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    id_pc_next_d = id_pc_next_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack_i) begin
          if (squash_q || br_valid_i) begin
            // The returning word belongs to a squashed path; restart at the newest target.
            pc_d     = br_valid_i ? br_tgt_s : tgt_q;
            squash_d = 1'b0;
          end else begin
            instr_d      = imem_rdata_i;
            id_pc_d      = pc_q;
            id_pc_next_d = pc_inc_s;
            pc_d         = pc_inc_s;
            valid_d      = 1'b1;
            state_d      = ST_HOLD;
          end
        end else if (br_valid_i) begin
          // Address must stay stable until ack, so park the redirect.
          tgt_d    = br_tgt_s;
          squash_d = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (br_valid_i) begin
          valid_d = 1'b0;
          pc_d    = br_tgt_s;
          state_d = ST_REQ;
        end else if (id_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pc_d     = RESET_PC;
        squash_d = 1'b0;
        valid_d  = 1'b0;
      end
    endcase
    req_d = (state_d == ST_REQ);
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign id_valid_o   = valid_q;
  assign id_instr_o   = instr_q;
  assign id_pc_o      = id_pc_q;
  assign id_pc_next_o = id_pc_next_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_s;

  assign stall_s = (req_q & ~imem_ack_i) | (valid_q & ~id_ready_i);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a transaction model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        br_valid = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic [7:0]  id_pc_next;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];

  // Transaction-level model of what fetch should present.
  logic        m_idle, m_valid, m_squash;
  logic [7:0]  m_addr, m_tgt, m_pc;
  logic [15:0] m_instr;
  int          m_stall;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .br_valid_i   (br_valid),
    .br_target_i  (br_target),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_instr_o   (id_instr),
    .id_pc_o      (id_pc),
`ifdef FETCH_PERF_EN
    .id_pc_next_o (id_pc_next),
    .stall_cnt_o  (stall_cnt)
`else
    .id_pc_next_o (id_pc_next)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idle = 1'b1; m_valid = 1'b0; m_squash = 1'b0;
    m_addr = 8'h00; m_tgt = 8'h00; m_pc = 8'h00; m_instr = 16'h0000;
    m_stall = 0;
  endtask

  task automatic model_update(input logic ack, input logic rdy, input logic br, input logic [7:0] tgt);
    logic [7:0] t;
    t = tgt & 8'hFE;
    if (((!m_idle && !m_valid && !ack) || (m_valid && !rdy)) && m_stall < 65535) m_stall++;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_valid) begin
      if (br) begin m_valid = 1'b0; m_addr = t; end
      else if (rdy) m_valid = 1'b0;
    end else if (ack) begin
      if (m_squash || br) begin m_addr = br ? t : m_tgt; m_squash = 1'b0; end
      else begin m_valid = 1'b1; m_pc = m_addr; m_instr = mem[m_addr]; m_addr = m_addr + 8'd2; end
    end else if (br) begin
      m_tgt = t; m_squash = 1'b1;
    end
  endtask

  task automatic step(input logic ack, input logic rdy, input logic br, input logic [7:0] tgt);
    imem_ack   = ack & imem_req;
    imem_rdata = imem_ack ? mem[imem_addr] : 16'($urandom);
    id_ready   = rdy;
    br_valid   = br;
    br_target  = tgt;
    @(posedge clk);
    model_update(imem_ack, rdy, br, tgt);
    #1;
    imem_ack = 1'b0;
    br_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; br_valid = 1'b0; id_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic run_until_req(input logic [7:0] a);
    int n;
    n = 0;
    while (!(imem_req && imem_addr == a) && n < 200) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL reach_req addr=%h: timed out, imem_addr=%h", a, imem_addr); end
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++; if (imem_req !== 1'b0)      begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 8'h00)    begin errors++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
    checks++; if (id_valid !== 1'b0)      begin errors++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 16'h0000)  begin errors++; $display("FAIL rst_instr got=%h exp=0000", id_instr); end
    checks++; if (id_pc !== 8'h00)        begin errors++; $display("FAIL rst_pc got=%h exp=00", id_pc); end
    checks++; if (id_pc_next !== 8'h00)   begin errors++; $display("FAIL rst_pc_next got=%h exp=00", id_pc_next); end
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL first_req got=%b/%h exp=1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_pc, exp_nx;
    int n;
    do_reset();
    exp_pc = 8'h00; n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (id_valid) begin
        exp_nx = exp_pc + 8'd2;
        checks++; if (id_pc !== exp_pc)       begin errors++; $display("FAIL stream_pc got=%h exp=%h", id_pc, exp_pc); end
        checks++; if (id_pc_next !== exp_nx)  begin errors++; $display("FAIL stream_pc_next got=%h exp=%h", id_pc_next, exp_nx); end
        checks++; if (id_instr !== mem[exp_pc]) begin errors++; $display("FAIL stream_instr got=%h exp=%h", id_instr, mem[exp_pc]); end
        exp_pc = exp_nx; n++;
      end
    end
    checks++; if (n < 5) begin errors++; $display("FAIL stream_count got=%0d exp>=5", n); end
  endtask

  task automatic test_ack_delay();
    int n;
    do_reset();
    run_until_req(8'h04);
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin
        errors++; $display("FAIL delay_hold got=%b/%h exp=1/04", imem_req, imem_addr);
      end
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin
      errors++; $display("FAIL delay_hold4 got=%b/%h exp=1/04", imem_req, imem_addr);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (id_valid && id_pc == 8'h04) n++;
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL delay_once got=%0d exp=1", n); end
  endtask

  task automatic test_hold_stall();
    logic [15:0] snap_instr;
`ifdef FETCH_PERF_EN
    logic [15:0] s0, s_exp;
`endif
    do_reset();
    run_until_req(8'h02);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    snap_instr = id_instr;
    checks++; if (id_valid !== 1'b1 || id_pc !== 8'h02) begin
      errors++; $display("FAIL hold_enter got=%b/%h exp=1/02", id_valid, id_pc);
    end
`ifdef FETCH_PERF_EN
    s0 = stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      checks++; if (id_valid !== 1'b1 || id_pc !== 8'h02 || id_instr !== snap_instr || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold_stable got=%b/%h/%h/%b exp=1/02/%h/0", id_valid, id_pc, id_instr, imem_req, snap_instr);
      end
    end
`ifdef FETCH_PERF_EN
    s_exp = s0 + 16'd5;
    checks++; if (stall_cnt !== s_exp) begin errors++; $display("FAIL hold_stall_cnt got=%0d exp=%0d", stall_cnt, s_exp); end
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h04) begin
      errors++; $display("FAIL hold_release got=%b/%b/%h exp=0/1/04", id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_req();
    do_reset();
    run_until_req(8'h10);
    step(1'b0, 1'b1, 1'b1, 8'h41);
    checks++; if (imem_addr !== 8'h10) begin errors++; $display("FAIL brreq_stable1 got=%h exp=10", imem_addr); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (imem_addr !== 8'h10) begin errors++; $display("FAIL brreq_stable2 got=%h exp=10", imem_addr); end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      errors++; $display("FAIL brreq_drop got=%b/%b/%h exp=0/1/40", id_valid, imem_req, imem_addr);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (id_valid !== 1'b1 || id_pc !== 8'h40 || id_instr !== mem[8'h40]) begin
      errors++; $display("FAIL brreq_deliver got=%b/%h/%h exp=1/40/%h", id_valid, id_pc, id_instr, mem[8'h40]);
    end
  endtask

  task automatic test_branch_hold();
    do_reset();
    run_until_req(8'h06);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h20);
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h20) begin
      errors++; $display("FAIL brhold got=%b/%b/%h exp=0/1/20", id_valid, imem_req, imem_addr);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (id_pc !== 8'h20) begin errors++; $display("FAIL brhold_pc got=%h exp=20", id_pc); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    run_until_req(8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    checks++; if (imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_align got=%h exp=FE", imem_addr); end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (id_pc !== 8'hFE || id_pc_next !== 8'h00) begin
      errors++; $display("FAIL wrap_pc got=%h/%h exp=FE/00", id_pc, id_pc_next);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL wrap_next got=%b/%h exp=1/00", imem_req, imem_addr);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin
      errors++; $display("FAIL midreq_setup got=%b/%h exp=1/02", imem_req, imem_addr);
    end
    rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || id_valid !== 1'b0) begin
      errors++; $display("FAIL midreq_rst got=%b/%h/%b exp=0/00/0", imem_req, imem_addr, id_valid);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL midreq_restart got=%b/%h exp=1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic        exp_req;
    logic [7:0]  exp_nx;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), 8'($urandom));
      exp_req = !m_idle && !m_valid;
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_addr); end
      end
      checks++; if (id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, id_valid, m_valid); end
      if (m_valid) begin
        exp_nx = m_pc + 8'd2;
        checks++; if (id_pc !== m_pc || id_pc_next !== exp_nx || id_instr !== m_instr) begin
          errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, id_pc, id_pc_next, id_instr, m_pc, exp_nx, m_instr);
        end
      end
`ifdef FETCH_PERF_EN
      checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();
    test_reset();
    test_stream();
    test_ack_delay();
    test_hold_stall();
    test_branch_req();
    test_branch_hold();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
